// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - multi-stage trigger engine with post-trigger sample gate
// Optional stage fallback timeout: define TRIGSEQ_TIMEOUT_EN.
module trigger_sequencer #(
  parameter int size    = 32,
  parameter int stages  = 8,
  parameter int cnt_w   = 16,
  parameter int saddr_w = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [size-1:0]            sample_data,
  input  logic                       sample_valid,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [$clog2(stages+1)-1:0] num_stages,
  input  logic [stages*size-1:0]     trig_mask,
  input  logic [stages*size-1:0]     trig_type,
  input  logic [stages*size-1:0]     trig_level,
  input  logic [stages*cnt_w-1:0]    trig_count,
  input  logic [cnt_w-1:0]           stage_timeout,
  input  logic [saddr_w-1:0]         post_trigger_count,
  output logic [size-1:0]            out_tdata,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic                       overrun,
  output logic [$clog2(stages)-1:0]  cur_stage
);
  localparam int nsw = $clog2(stages + 1);
  localparam int sw  = $clog2(stages);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] POST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [cnt_w-1:0]   occ_cnt;
  logic [saddr_w-1:0] post_cnt;
  logic [size-1:0]    prev_data;
  logic               prev_valid;

  logic [size-1:0]  cur_mask, cur_type, cur_level, bit_eq, bit_ok;
  logic [cnt_w-1:0] cur_count, eff_count;
  logic [nsw-1:0]   ns_eff;
  logic             match, occ_hit, is_last, can_load;

  always_comb begin
    cur_mask  = '0;
    cur_type  = '0;
    cur_level = '0;
    cur_count = '0;
    for (int k = 0; k < stages; k++) begin
      if (cur_stage == sw'(k)) begin
        cur_mask  = trig_mask[k*size +: size];
        cur_type  = trig_type[k*size +: size];
        cur_level = trig_level[k*size +: size];
        cur_count = trig_count[k*cnt_w +: cnt_w];
      end
    end
  end

  // Edge bits additionally need the previous valid sample to differ from the target.
  assign bit_eq    = ~(sample_data ^ cur_level);
  assign bit_ok    = (~cur_type & bit_eq)
                   | (cur_type & bit_eq & (prev_data ^ cur_level) & {size{prev_valid}});
  assign match     = &(~cur_mask | bit_ok);
  assign eff_count = (cur_count == '0) ? cnt_w'(1) : cur_count;
  assign occ_hit   = ({1'b0, occ_cnt} + (cnt_w+1)'(1)) >= {1'b0, eff_count};
  assign ns_eff    = (num_stages == '0) ? nsw'(1)
                   : (num_stages > nsw'(stages)) ? nsw'(stages) : num_stages;
  assign is_last   = nsw'(cur_stage) >= (ns_eff - nsw'(1));
  assign can_load  = !out_tvalid || out_tready;

`ifdef TRIGSEQ_TIMEOUT_EN
  logic [cnt_w-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^stage_timeout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      occ_cnt    <= '0;
      post_cnt   <= '0;
      prev_data  <= '0;
      prev_valid <= 1'b0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      armed      <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      cur_stage  <= '0;
`ifdef TRIGSEQ_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      if (out_tvalid && out_tready)
        out_tvalid <= 1'b0;
      if (sample_valid) begin
        prev_data  <= sample_data;
        prev_valid <= 1'b1;
      end
      if (abort) begin
        state      <= IDLE;
        armed      <= 1'b0;
        done       <= 1'b0;
        out_tvalid <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              state      <= WAIT;
              armed      <= 1'b1;
              done       <= 1'b0;
              triggered  <= 1'b0;
              overrun    <= 1'b0;
              cur_stage  <= '0;
              occ_cnt    <= '0;
              prev_valid <= 1'b0;
`ifdef TRIGSEQ_TIMEOUT_EN
              to_cnt     <= '0;
`endif
            end
          end
          WAIT: begin
            if (sample_valid) begin
              if (match && occ_hit) begin
                occ_cnt <= '0;
`ifdef TRIGSEQ_TIMEOUT_EN
                to_cnt  <= '0;
`endif
                if (is_last) begin
                  state     <= (post_trigger_count == '0) ? DONE : POST;
                  done      <= (post_trigger_count == '0);
                  triggered <= 1'b1;
                  armed     <= 1'b0;
                  post_cnt  <= post_trigger_count;
                  if (can_load) begin
                    out_tdata  <= sample_data;
                    out_tvalid <= 1'b1;
                  end else begin
                    overrun <= 1'b1;
                  end
                end else begin
                  cur_stage <= cur_stage + sw'(1);
                end
              end else begin
                if (match)
                  occ_cnt <= occ_cnt + cnt_w'(1);
`ifdef TRIGSEQ_TIMEOUT_EN
                // Falling back clears the partial occurrence count of the abandoned stage.
                if (cur_stage != '0) begin
                  if (stage_timeout != '0 &&
                      ({1'b0, to_cnt} + (cnt_w+1)'(1)) >= {1'b0, stage_timeout}) begin
                    cur_stage <= '0;
                    occ_cnt   <= '0;
                    to_cnt    <= '0;
                  end else begin
                    to_cnt <= to_cnt + cnt_w'(1);
                  end
                end
`endif
              end
            end
          end
          POST: begin
            if (sample_valid) begin
              if (can_load) begin
                out_tdata  <= sample_data;
                out_tvalid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              // Dropped samples still consume the post-trigger budget.
              if (post_cnt <= saddr_w'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end
              post_cnt <= post_cnt - saddr_w'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - directed vector bench for trigger_sequencer
module tb_trigger_sequencer;
  localparam int SIZE = 8;
  localparam int STAGES = 4;
  localparam int CW = 8;
  localparam int SAW = 8;
`ifdef TRIGSEQ_TIMEOUT_EN
  localparam logic [1:0] TO_STAGE = 2'd0;
`else
  localparam logic [1:0] TO_STAGE = 2'd1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [SIZE-1:0] sample_data = '0;
  logic sample_valid = 1'b0, arm = 1'b0, abort = 1'b0, out_tready = 1'b1;
  logic [2:0] num_stages = 3'd1;
  logic [STAGES*SIZE-1:0] trig_mask = '0, trig_type = '0, trig_level = '0;
  logic [STAGES*CW-1:0] trig_count = '0;
  logic [CW-1:0] stage_timeout = '0;
  logic [SAW-1:0] post_trigger_count = '0;
  logic [SIZE-1:0] out_tdata;
  logic out_tvalid, armed, triggered, done, overrun;
  logic [1:0] cur_stage;

  int checks = 0;
  int errors = 0;

  trigger_sequencer #(.size(SIZE), .stages(STAGES), .cnt_w(CW), .saddr_w(SAW)) dut (
    .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
    .arm(arm), .abort(abort), .num_stages(num_stages), .trig_mask(trig_mask),
    .trig_type(trig_type), .trig_level(trig_level), .trig_count(trig_count),
    .stage_timeout(stage_timeout), .post_trigger_count(post_trigger_count),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .armed(armed), .triggered(triggered), .done(done), .overrun(overrun),
    .cur_stage(cur_stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic arm, abort, valid;
    logic [7:0] data;
    logic ready;
    logic e_tvalid;
    logic [7:0] e_tdata;
    logic e_armed, e_trig, e_done, e_ovr;
    logic [1:0] e_stage;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic ab, input logic v, input logic [7:0] d,
                     input logic r);
    @(negedge clk);
    arm = a; abort = ab; sample_valid = v; sample_data = d; out_tready = r;
    @(posedge clk);
    #1;
    arm = 1'b0; abort = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic add(input logic a, input logic ab, input logic v, input logic [7:0] d,
                     input logic r, input logic etv, input logic [7:0] etd,
                     input logic ea, input logic et, input logic ed, input logic eo,
                     input logic [1:0] es);
    vec_t x;
    x.arm = a; x.abort = ab; x.valid = v; x.data = d; x.ready = r;
    x.e_tvalid = etv; x.e_tdata = etd; x.e_armed = ea; x.e_trig = et;
    x.e_done = ed; x.e_ovr = eo; x.e_stage = es;
    vq.push_back(x);
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].arm, vq[i].abort, vq[i].valid, vq[i].data, vq[i].ready);
      chk($sformatf("%s_v%0d_status", tag, i),
          {26'd0, out_tvalid, armed, triggered, done, overrun, cur_stage[0] ^ 1'b0} |
          {30'd0, cur_stage} << 6,
          {26'd0, vq[i].e_tvalid, vq[i].e_armed, vq[i].e_trig, vq[i].e_done, vq[i].e_ovr,
           vq[i].e_stage[0]} | {30'd0, vq[i].e_stage} << 6);
      if (vq[i].e_tvalid)
        chk($sformatf("%s_v%0d_tdata", tag, i), {24'd0, out_tdata}, {24'd0, vq[i].e_tdata});
    end
    vq.delete();
  endtask

  task automatic set_stage(input int k, input logic [7:0] m, input logic [7:0] t,
                           input logic [7:0] l, input logic [7:0] c);
    trig_mask[k*SIZE +: SIZE] = m;
    trig_type[k*SIZE +: SIZE] = t;
    trig_level[k*SIZE +: SIZE] = l;
    trig_count[k*CW +: CW] = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, out_tvalid, armed, triggered, done, overrun, cur_stage, out_tdata[2:0]}, 32'd0);

    // Single level stage, post=3; out stream 1,2,3,4 with accept+load every cycle.
    num_stages = 3'd1; post_trigger_count = 8'd3;
    set_stage(0, 8'h01, 8'h00, 8'h01, 8'd0);
    add(1,0,0,0,1, 0,0, 1,0,0,0,0);
    add(0,0,1,0,1, 0,0, 1,0,0,0,0);
    add(0,0,1,0,1, 0,0, 1,0,0,0,0);
    add(0,0,1,1,1, 1,1, 0,1,0,0,0);
    add(0,0,1,2,1, 1,2, 0,1,0,0,0);
    add(0,0,1,3,1, 1,3, 0,1,0,0,0);
    add(0,0,1,4,1, 1,4, 0,1,1,0,0);
    add(0,0,0,0,1, 0,0, 0,1,1,0,0);
    add(0,0,1,5,1, 0,0, 0,1,1,0,0);
    run_vectors("s1");

    // Two stages: rising edge on bit0 twice, then level bit1; post=0.
    num_stages = 3'd2; post_trigger_count = 8'd0;
    set_stage(0, 8'h01, 8'h01, 8'h01, 8'd2);
    set_stage(1, 8'h02, 8'h00, 8'h02, 8'd1);
    add(1,0,0,0,1, 0,0, 1,0,0,0,0);
    add(0,0,1,1,1, 0,0, 1,0,0,0,0);
    add(0,0,1,0,1, 0,0, 1,0,0,0,0);
    add(0,0,1,1,1, 0,0, 1,0,0,0,0);
    add(1,0,0,0,1, 0,0, 1,0,0,0,0);
    add(0,0,1,0,1, 0,0, 1,0,0,0,0);
    add(0,0,1,1,1, 0,0, 1,0,0,0,1);
    add(0,0,0,2,1, 0,0, 1,0,0,0,1);
    add(0,0,1,2,1, 1,2, 0,1,1,0,1);
    add(0,0,0,0,1, 0,0, 0,1,1,0,1);
    run_vectors("s2");

    // Abort with arm in POST; num_stages=0 behaves as one stage.
    num_stages = 3'd0; post_trigger_count = 8'd3;
    set_stage(0, 8'h01, 8'h00, 8'h01, 8'd0);
    cyc(1,0,0,0,1);
    chk("ab_arm_stage", {30'd0, cur_stage}, 32'd0);
    chk("ab_arm_flags", {29'd0, armed, triggered, done}, 32'b100);
    cyc(0,0,1,1,1);
    chk("ab_trig", {30'd0, triggered, out_tvalid}, 32'b11);
    cyc(1,1,1,1,1);
    chk("ab_abort", {29'd0, armed, done, out_tvalid}, 32'd0);
    cyc(0,0,1,1,1);
    chk("ab_idle", {30'd0, armed, out_tvalid}, 32'd0);
    cyc(1,0,0,0,1);
    chk("ab_rearm", {29'd0, armed, triggered, 1'b0} | {30'd0, cur_stage}, 32'b100);
    cyc(0,1,1,1,1);
    chk("ab_over_match", {29'd0, armed, triggered, out_tvalid}, 32'd0);

    // Backpressure in POST, post=4.
    num_stages = 3'd1; post_trigger_count = 8'd4;
    cyc(1,0,0,0,0);
    cyc(0,0,1,1,0);
    chk("ov_trig", {23'd0, out_tvalid, overrun, out_tdata}, {23'd0, 1'b1, 1'b0, 8'd1});
    cyc(0,0,1,2,0);
    chk("ov_drop", {23'd0, out_tvalid, overrun, out_tdata}, {23'd0, 1'b1, 1'b1, 8'd1});
    cyc(0,0,1,3,0);
    cyc(0,0,1,4,0);
    chk("ov_not_done", {31'd0, done}, 32'd0);
    cyc(0,0,1,5,0);
    chk("ov_done", {22'd0, done, out_tvalid, overrun, out_tdata}, {22'd0, 3'b111, 8'd1});
    cyc(0,0,0,0,1);
    chk("ov_drain", {30'd0, out_tvalid, overrun}, 32'b01);
    cyc(1,0,0,0,1);
    chk("ov_arm_clears", {30'd0, overrun, done}, 32'd0);

    // Stage timeout: stage0 matches anything, stage1 waits for bit0=1.
    cyc(0,1,0,0,1);
    num_stages = 3'd2; stage_timeout = 8'd3;
    set_stage(0, 8'h00, 8'h00, 8'h00, 8'd1);
    set_stage(1, 8'h01, 8'h00, 8'h01, 8'd1);
    cyc(1,0,0,0,1);
    cyc(0,0,1,0,1);
    chk("to_enter1", {30'd0, cur_stage}, 32'd1);
    cyc(0,0,1,0,1);
    cyc(0,0,1,0,1);
    chk("to_hold", {30'd0, cur_stage}, 32'd1);
    cyc(0,0,1,0,1);
    chk("to_fallback", {30'd0, cur_stage}, {30'd0, TO_STAGE});
    cyc(0,0,1,0,1);
    chk("to_reenter", {30'd0, cur_stage}, 32'd1);
    cyc(0,0,1,1,0);
    chk("to_trig", {22'd0, triggered, out_tvalid, out_tdata}, {22'd0, 2'b11, 8'd1});

    // Asynchronous reset in the middle of POST.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {21'd0, out_tvalid, armed, triggered, done, overrun, cur_stage, out_tdata[3:0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0,0,1,1,1);
    chk("reset_idle", {29'd0, armed, triggered, out_tvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
